// File: rtl/rv_pkg.sv
// rv_pkg: shared widths, RV32M funct3 codes, muldiv FSM states and operand signedness helpers
package rv_pkg;
  localparam int XLEN = 32;
  localparam int CNT_W = 5;
  localparam logic [2:0] MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_MULHU = 3'd3;
  localparam logic [2:0] MD_DIV = 3'd4, MD_DIVU = 3'd5, MD_REM = 3'd6, MD_REMU = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} md_state_t;
  function automatic logic a_signed(input logic [2:0] op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction
  function automatic logic b_signed(input logic [2:0] op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction
  function automatic logic is_unsigned_op(input logic [2:0] op);
    return op inside {MD_MULHU, MD_DIVU, MD_REMU};
  endfunction
endpackage

// File: rtl/muldiv_iter_engine.sv
// muldiv_iter_engine: iterative RV32M engine (start/ack/op/a/b in; busy/done/fast/result out); shift-add multiply, restoring divide, 1-cycle div-by-zero/overflow fast path
module muldiv_iter_engine
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            ack,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic            fast,
  output logic [XLEN-1:0] result
);
  md_state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2*XLEN-1:0] acc, prod;
  logic [XLEN-1:0] mag_b, abs_a, abs_b, quo, rem, fast_res;
  logic [XLEN:0] mul_sum;
  logic [XLEN+1:0] div_diff;
  logic [2:0] op_r;
  logic neg_a, neg_b, sa, sb, ovf;
  assign sa = a_signed(op) & a[XLEN-1];
  assign sb = b_signed(op) & b[XLEN-1];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;
  assign ovf = (op == MD_DIV || op == MD_REM) && a == {1'b1, {(XLEN-1){1'b0}}} && &b;
  assign fast = op[2] & (b == '0 | ovf);
  // op[1] separates REM* from DIV*
  assign fast_res = op[1] ? (ovf ? '0 : a) : (ovf ? a : '1);
  // acc low half holds the multiplier (shifted out LSB first) or the dividend (shifted out MSB first)
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b} : '0);
  assign div_diff = {1'b0, acc[2*XLEN-1:XLEN-1]} - {2'b0, mag_b};
  assign prod = (neg_a ^ neg_b) ? -acc : acc;
  assign quo = (neg_a ^ neg_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
  assign result = state != ST_DONE ? fast_res : op_r[2] ? (op_r[1] ? rem : quo) :
                  op_r == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign busy = state == ST_BUSY;
  assign done = state == ST_DONE;
  always_ff @(posedge clk) state <= rst ? ST_IDLE : state_n;
  always_comb
    state_n = state == ST_IDLE ? (start & ~fast ? ST_BUSY : ST_IDLE) :
              state == ST_BUSY ? (cnt == CNT_W'(XLEN-1) ? ST_DONE : ST_BUSY) :
              ack ? ST_IDLE : ST_DONE;
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      acc <= '0;
      mag_b <= '0;
      op_r <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
    end else if (state == ST_IDLE && start && !fast) begin
      cnt <= '0;
      acc <= {{XLEN{1'b0}}, abs_a};
      mag_b <= abs_b;
      op_r <= op;
      neg_a <= sa;
      neg_b <= sb;
    end else if (state == ST_BUSY) begin
      cnt <= cnt + 1'b1;
      acc <= !op_r[2] ? {mul_sum, acc[XLEN-1:1]} :
             div_diff[XLEN+1] ? {acc[2*XLEN-2:0], 1'b0} : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end
endmodule

// File: rtl/execute_muldiv_stage.sv
// execute_muldiv_stage: execute stage + E->M register (E controls/data in, M controls/data out, StallE = md busy | MemWaitM); MULDIV_FAST_MUL_EN makes multiplies single-cycle
module execute_muldiv_stage
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            FRegWriteE,
  input  logic            MemWriteE,
  input  logic            ResultSrcE,
  input  logic            fstoreE,
  input  logic            floadE,
  input  logic [4:0]      RD_E,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] FPU_ResultE,
  input  logic            MdEnE,
  input  logic [2:0]      MdOpE,
  input  logic            FlushE,
  input  logic            MemWaitM,
  output logic            RegWriteM,
  output logic            FRegWriteM,
  output logic            MemWriteM,
  output logic            ResultSrcM,
  output logic            fstoreM,
  output logic            floadM,
  output logic [4:0]      RD_M,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] ALU_ResultM,
  output logic [XLEN-1:0] FPU_ResultEM,
  output logic            StallE
);
  logic eng_busy, eng_done, eng_fast, md_fast, md_busy, load;
  logic [XLEN-1:0] eng_res, md_res;
  muldiv_iter_engine u_eng (
    .clk(clk), .rst(rst), .start(MdEnE & ~md_fast), .ack(~MemWaitM), .op(MdOpE),
    .a(SrcAE), .b(SrcBE), .busy(eng_busy), .done(eng_done), .fast(eng_fast), .result(eng_res)
  );
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fm;
  assign fm = $signed({a_signed(MdOpE) & SrcAE[XLEN-1], SrcAE}) * $signed({b_signed(MdOpE) & SrcBE[XLEN-1], SrcBE});
  assign md_fast = eng_fast | ~MdOpE[2];
  assign md_res = MdOpE[2] ? eng_res : MdOpE == MD_MUL ? fm[XLEN-1:0] : fm[2*XLEN-1:XLEN];
`else
  assign md_fast = eng_fast;
  assign md_res = eng_res;
`endif
  assign md_busy = ~rst & (eng_busy | (MdEnE & ~md_fast & ~eng_done));
  assign StallE = md_busy | MemWaitM;
  assign load = ~StallE;
  always_ff @(posedge clk)
    if (rst) begin
      {RegWriteM, FRegWriteM, MemWriteM, ResultSrcM, fstoreM, floadM} <= '0;
      RD_M <= '0;
      PCPlus4M <= '0;
      WriteDataM <= '0;
      ALU_ResultM <= '0;
      FPU_ResultEM <= '0;
    end else if (load) begin
      {RegWriteM, FRegWriteM, MemWriteM, ResultSrcM, fstoreM, floadM} <=
        FlushE ? '0 : {RegWriteE, FRegWriteE, MemWriteE, ResultSrcE, fstoreE, floadE};
      RD_M <= RD_E;
      PCPlus4M <= PCPlus4E;
      WriteDataM <= WriteDataE;
      ALU_ResultM <= MdEnE ? md_res : ALUResultE;
      FPU_ResultEM <= FPU_ResultE;
    end
endmodule

// File: tb/tb_execute_muldiv_stage.sv
// tb_execute_muldiv_stage: scoreboard bench with a behavioural RV32M reference model
module tb_execute_muldiv_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic RegWriteE, FRegWriteE, MemWriteE, ResultSrcE, fstoreE, floadE, MdEnE, FlushE, MemWaitM;
  logic [4:0] RD_E, RD_M;
  logic [2:0] MdOpE;
  logic [31:0] PCPlus4E, WriteDataE, SrcAE, SrcBE, ALUResultE, FPU_ResultE;
  logic RegWriteM, FRegWriteM, MemWriteM, ResultSrcM, fstoreM, floadM, StallE;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM, FPU_ResultEM;
  typedef struct packed {
    logic [5:0] ctl;
    logic [4:0] rd;
    logic [31:0] pc4, wd, alu, fpu;
  } m_t;
  m_t sb[$];
  m_t prev, act;
  int total = 0, bad = 0;
  logic mon_will;
  logic [31:0] edge_v [7] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2, 32'hFFFF_FFF9};
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_STALL = 0;
`else
  localparam int MUL_STALL = 33;
`endif

  execute_muldiv_stage dut (
    .clk(clk), .rst(rst), .RegWriteE(RegWriteE), .FRegWriteE(FRegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .fstoreE(fstoreE), .floadE(floadE), .RD_E(RD_E), .PCPlus4E(PCPlus4E),
    .WriteDataE(WriteDataE), .SrcAE(SrcAE), .SrcBE(SrcBE), .ALUResultE(ALUResultE), .FPU_ResultE(FPU_ResultE),
    .MdEnE(MdEnE), .MdOpE(MdOpE), .FlushE(FlushE), .MemWaitM(MemWaitM), .RegWriteM(RegWriteM),
    .FRegWriteM(FRegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .fstoreM(fstoreM),
    .floadM(floadM), .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM),
    .FPU_ResultEM(FPU_ResultEM), .StallE(StallE)
  );

  always #5 clk = ~clk;
  assign act = {RegWriteM, FRegWriteM, MemWriteM, ResultSrcM, fstoreM, floadM, RD_M, PCPlus4M, WriteDataM, ALU_ResultM, FPU_ResultEM};

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] md_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic [31:0] r;
    logic ovf;
    int sa, sb2;
    ea = (op < 3'd3 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb = (op < 3'd2 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p = ea * eb;
    sa = a;
    sb2 = b;
    ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    case (op)
      3'd0: r = p[31:0];
      3'd1, 3'd2, 3'd3: r = p[63:32];
      3'd4: r = b == 0 ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb2);
      3'd5: r = b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: r = b == 0 ? a : ovf ? 32'h0 : 32'(sa % sb2);
      default: r = b == 0 ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int stall_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return MUL_STALL;
    if (b == 0 || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 0;
    return 33;
  endfunction

  task automatic drive_zero();
    {RegWriteE, FRegWriteE, MemWriteE, ResultSrcE, fstoreE, floadE, MdEnE, FlushE} = '0;
    RD_E = '0; MdOpE = '0; PCPlus4E = '0; WriteDataE = '0; SrcAE = '0; SrcBE = '0; ALUResultE = '0; FPU_ResultE = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_zero();
      MemWaitM = 1'b0;
      rst = 1'b0;
      sb.push_back('0);
      prev = '0;
    end
  endtask

  task automatic issue(input string nm, input logic md, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] alu, input logic fl, input int hold);
    m_t e;
    int stalls, es;
    @(negedge clk);
    {RegWriteE, FRegWriteE, MemWriteE, ResultSrcE, fstoreE, floadE} = 6'($urandom);
    RD_E = 5'($urandom); PCPlus4E = $urandom; WriteDataE = $urandom; FPU_ResultE = $urandom;
    ALUResultE = alu; SrcAE = a; SrcBE = b; MdEnE = md; MdOpE = op; FlushE = fl; MemWaitM = 1'b0;
    e = {fl ? 6'b0 : {RegWriteE, FRegWriteE, MemWriteE, ResultSrcE, fstoreE, floadE}, RD_E, PCPlus4E,
         WriteDataE, md ? md_model(op, a, b) : alu, FPU_ResultE};
    es = md ? stall_model(op, a, b) : 0;
    sb.push_back(e);
    stalls = 0;
    #1;
    while (StallE && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    chk({nm, " stall_cycles"}, stalls, es);
    for (int i = 0; i < hold; i++) begin
      MemWaitM = 1'b1;
      #1;
      chk({nm, " wait_stall"}, StallE, 1'b1);
      @(posedge clk);
      #1;
      chk({nm, " held_m"}, act, prev);
      @(negedge clk);
    end
    MemWaitM = 1'b0;
    prev = e;
  endtask

  initial forever begin
    @(negedge clk);
    #3;
    mon_will = !rst && !StallE;
    @(posedge clk);
    #1;
    if (mon_will) begin
      if (sb.size() == 0) chk("unexpected_load", act, 160'h0 - 1);
      else chk("m_reg", act, sb.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    drive_zero();
    MemWaitM = 1'b1;
    prev = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_m", act, '0);
    chk("reset_stall_wait", StallE, 1'b1);
    MemWaitM = 1'b0;
    #1;
    chk("reset_stall_nowait", StallE, 1'b0);
    idle(1);
    issue("alu_1234", 0, 0, 0, 0, 32'h1234, 0, 0);
    issue("div_m7_2", 1, 3'd4, 32'hFFFF_FFF9, 2, 0, 0, 0);
    issue("rem_m7_2", 1, 3'd6, 32'hFFFF_FFF9, 2, 0, 0, 0);
    issue("divu_5_0", 1, 3'd5, 5, 0, 0, 0, 0);
    issue("rem_5_0", 1, 3'd6, 5, 0, 0, 0, 0);
    issue("div_ovf", 1, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    issue("rem_ovf", 1, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    issue("mulhu_max", 1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    issue("mulhsu_m1_2", 1, 3'd2, 32'hFFFF_FFFF, 2, 0, 0, 0);
    issue("div_hold5", 1, 3'd4, 32'hFFFF_FFF9, 2, 0, 0, 5);
    issue("mul_after_hold", 1, 3'd0, 32'hFFFF_FFFD, 7, 0, 0, 0);
    issue("alu_flush", 0, 0, 0, 0, 32'hABCD, 1, 2);
    @(negedge clk);
    {RegWriteE, FRegWriteE, MemWriteE, ResultSrcE, fstoreE, floadE} = '1;
    MdEnE = 1'b1; MdOpE = 3'd4; SrcAE = 32'hFFFF_FFF9; SrcBE = 2; FlushE = 1'b0;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    drive_zero();
    #1;
    chk("rst_mid_stall", StallE, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_mid_m", act, '0);
    idle(1);
    issue("alu_after_rst", 0, 0, 0, 0, 32'h5A5A_0001, 0, 0);
    issue("divu_after_rst", 1, 3'd5, 100, 7, 0, 0, 0);
    for (int i = 0; i < 60; i++) begin
      logic md;
      logic [2:0] op;
      logic [31:0] a, b;
      md = 1'($urandom);
      op = 3'($urandom);
      a = $urandom_range(0, 1) ? edge_v[$urandom_range(0, 6)] : $urandom;
      b = $urandom_range(0, 1) ? edge_v[$urandom_range(0, 6)] : $urandom;
      issue("rand", md, op, a, b, $urandom, !md && $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0);
    end
    idle(2);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
